// File: rtl/mem_stage.sv
// Memory stage between Execute and Writeback: single-cycle pass-through for ALU/vector
// results, request/acknowledge data-memory access for LDW/STW with upstream stall and timeout abort.
module mem_stage #(
  parameter int REG_WIDTH      = 32,
  parameter int VREG_WIDTH     = 64,
  parameter int PC_WIDTH       = 32,
  parameter int IR_WIDTH       = 32,
  parameter int OPCODE_WIDTH   = 8,
  parameter int VREG_ID_WIDTH  = 6,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [OPCODE_WIDTH-1:0] OP_LDW = 8'h50,
  parameter logic [OPCODE_WIDTH-1:0] OP_STW = 8'h54
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
  input  logic [IR_WIDTH-1:0]      I_IR,
  input  logic [PC_WIDTH-1:0]      I_PC,
  input  logic [3:0]               I_DestRegIdx,
  input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
  input  logic [REG_WIDTH-1:0]     I_DestValue,
  input  logic [VREG_WIDTH-1:0]    I_VecDestValue,
  input  logic [2:0]               I_CCValue,
  input  logic [REG_WIDTH-1:0]     I_MARValue,
  input  logic [REG_WIDTH-1:0]     I_MDRValue,
  input  logic                     I_EX_Valid,
  input  logic                     I_RegWEn,
  input  logic                     I_VRegWEn,
  input  logic                     I_CCWEn,
  output logic                     O_MemReq,
  output logic                     O_MemWrite,
  output logic [REG_WIDTH-1:0]     O_MemAddr,
  output logic [REG_WIDTH-1:0]     O_MemWData,
  input  logic                     I_MemAck,
  input  logic [REG_WIDTH-1:0]     I_MemRData,
  output logic                     O_MemStallSignal,
  output logic                     O_RegWEn_Signal,
  output logic                     O_VRegWEn_Signal,
  output logic                     O_CCWEn_Signal,
  output logic                     O_LOCK,
  output logic [OPCODE_WIDTH-1:0]  O_Opcode,
  output logic [IR_WIDTH-1:0]      O_IR,
  output logic [PC_WIDTH-1:0]      O_PC,
  output logic [3:0]               O_DestRegIdx,
  output logic [VREG_ID_WIDTH-1:0] O_DestVRegIdx,
  output logic [REG_WIDTH-1:0]     O_DestValue,
  output logic [VREG_WIDTH-1:0]    O_VecDestValue,
  output logic [2:0]               O_CCValue,
  output logic                     O_MEM_Valid,
  output logic                     O_RegWEn,
  output logic                     O_VRegWEn,
  output logic                     O_CCWEn,
  output logic                     O_MemError
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT_CYCLES - 1);

  state_t                   state_r;
  logic [7:0]               cnt_r;
  logic                     pend_ld_r;
  logic [OPCODE_WIDTH-1:0]  pend_opcode_r;
  logic [IR_WIDTH-1:0]      pend_ir_r;
  logic [PC_WIDTH-1:0]      pend_pc_r;
  logic [3:0]               pend_dreg_r;
  logic [VREG_ID_WIDTH-1:0] pend_dvreg_r;
  logic [REG_WIDTH-1:0]     pend_dval_r;
  logic [VREG_WIDTH-1:0]    pend_vdval_r;
  logic [2:0]               pend_cc_r;

  logic is_ldw_s;
  logic is_stw_s;
  logic mar_lo_unused_s;

  assign is_ldw_s        = (I_Opcode == OP_LDW);
  assign is_stw_s        = (I_Opcode == OP_STW);
  assign mar_lo_unused_s = ^I_MARValue[1:0];

  // Condition code of a loaded word, interpreted as signed: N=100, Z=010, P=001.
  function automatic logic [2:0] cc_of(input logic [REG_WIDTH-1:0] v);
    logic [2:0] cc;
    if (v[REG_WIDTH-1]) begin
      cc = 3'b100;
    end else if (v == {REG_WIDTH{1'b0}}) begin
      cc = 3'b010;
    end else begin
      cc = 3'b001;
    end
    return cc;
  endfunction

  assign O_MemStallSignal = (state_r == ST_BUSY) & ~I_MemAck;

  // Pending-write flags to Decode: the outstanding load while busy, otherwise the stage's own output.
  always_comb begin
    O_RegWEn_Signal  = O_RegWEn;
    O_VRegWEn_Signal = O_VRegWEn;
    O_CCWEn_Signal   = O_CCWEn;
    if (state_r == ST_BUSY) begin
      O_RegWEn_Signal  = pend_ld_r;
      O_VRegWEn_Signal = 1'b0;
      O_CCWEn_Signal   = pend_ld_r;
    end else begin
      O_RegWEn_Signal  = O_RegWEn;
      O_VRegWEn_Signal = O_VRegWEn;
      O_CCWEn_Signal   = O_CCWEn;
    end
  end

  // Stage state machine and registered Writeback bundle, updated on the falling edge.
  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 8'd0;
      pend_ld_r      <= 1'b0;
      pend_opcode_r  <= '0;
      pend_ir_r      <= '0;
      pend_pc_r      <= '0;
      pend_dreg_r    <= 4'd0;
      pend_dvreg_r   <= '0;
      pend_dval_r    <= '0;
      pend_vdval_r   <= '0;
      pend_cc_r      <= 3'b000;
      O_MemReq       <= 1'b0;
      O_MemWrite     <= 1'b0;
      O_MemAddr      <= '0;
      O_MemWData     <= '0;
      O_LOCK         <= 1'b0;
      O_Opcode       <= '0;
      O_IR           <= '0;
      O_PC           <= '0;
      O_DestRegIdx   <= 4'd0;
      O_DestVRegIdx  <= '0;
      O_DestValue    <= '0;
      O_VecDestValue <= '0;
      O_CCValue      <= 3'b000;
      O_MEM_Valid    <= 1'b0;
      O_RegWEn       <= 1'b0;
      O_VRegWEn      <= 1'b0;
      O_CCWEn        <= 1'b0;
      O_MemError     <= 1'b0;
    end else begin
      O_MemError <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!I_LOCK) begin
            O_LOCK      <= 1'b0;
            O_MEM_Valid <= 1'b0;
            O_RegWEn    <= 1'b0;
            O_VRegWEn   <= 1'b0;
            O_CCWEn     <= 1'b0;
          end else if (I_EX_Valid && (is_ldw_s || is_stw_s)) begin
            pend_ld_r     <= is_ldw_s;
            pend_opcode_r <= I_Opcode;
            pend_ir_r     <= I_IR;
            pend_pc_r     <= I_PC;
            pend_dreg_r   <= I_DestRegIdx;
            pend_dvreg_r  <= I_DestVRegIdx;
            pend_dval_r   <= I_DestValue;
            pend_vdval_r  <= I_VecDestValue;
            pend_cc_r     <= I_CCValue;
            O_MemReq      <= 1'b1;
            O_MemWrite    <= is_stw_s;
            O_MemAddr     <= {I_MARValue[REG_WIDTH-1:2], 2'b00};
            O_MemWData    <= I_MDRValue;
            O_LOCK        <= 1'b1;
            O_MEM_Valid   <= 1'b0;
            O_RegWEn      <= 1'b0;
            O_VRegWEn     <= 1'b0;
            O_CCWEn       <= 1'b0;
            cnt_r         <= 8'd0;
            state_r       <= ST_BUSY;
          end else begin
            O_LOCK         <= 1'b1;
            O_Opcode       <= I_Opcode;
            O_IR           <= I_IR;
            O_PC           <= I_PC;
            O_DestRegIdx   <= I_DestRegIdx;
            O_DestVRegIdx  <= I_DestVRegIdx;
            O_DestValue    <= I_DestValue;
            O_VecDestValue <= I_VecDestValue;
            O_CCValue      <= I_CCValue;
            O_MEM_Valid    <= I_EX_Valid;
            O_RegWEn       <= I_RegWEn & I_EX_Valid;
            O_VRegWEn      <= I_VRegWEn & I_EX_Valid;
            O_CCWEn        <= I_CCWEn & I_EX_Valid;
          end
        end
        ST_BUSY: begin
          // Completion wins over timeout when the ack lands on the last allowed edge.
          if (I_MemAck) begin
            O_MemReq       <= 1'b0;
            O_LOCK         <= 1'b1;
            O_Opcode       <= pend_opcode_r;
            O_IR           <= pend_ir_r;
            O_PC           <= pend_pc_r;
            O_DestRegIdx   <= pend_dreg_r;
            O_DestVRegIdx  <= pend_dvreg_r;
            O_VecDestValue <= pend_vdval_r;
            O_DestValue    <= pend_ld_r ? I_MemRData : pend_dval_r;
            O_CCValue      <= pend_ld_r ? cc_of(I_MemRData) : pend_cc_r;
            O_MEM_Valid    <= 1'b1;
            O_RegWEn       <= pend_ld_r;
            O_VRegWEn      <= 1'b0;
            O_CCWEn        <= pend_ld_r;
            cnt_r          <= 8'd0;
            state_r        <= ST_IDLE;
          end else if (cnt_r == TO_LAST_C) begin
            O_MemReq    <= 1'b0;
            O_MemError  <= 1'b1;
            O_MEM_Valid <= 1'b0;
            O_RegWEn    <= 1'b0;
            O_VRegWEn   <= 1'b0;
            O_CCWEn     <= 1'b0;
            cnt_r       <= 8'd0;
            state_r     <= ST_IDLE;
          end else begin
            O_MEM_Valid <= 1'b0;
            O_RegWEn    <= 1'b0;
            O_VRegWEn   <= 1'b0;
            O_CCWEn     <= 1'b0;
            cnt_r       <= cnt_r + 8'd1;
          end
        end
        default: begin
          O_MemReq <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
